pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the payload width in bits; legal range is 1..256.
REQ-002 SHALL have parameter NOP_VAL, default 0 (DATA_W bits), giving the payload presented when no entry is valid.
REQ-003 SHALL have parameter CNT_W, default 16, giving the width of the back-pressure counter.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low; 0 at posedge = reset.
REQ-006 flush_i  input  1  discard all held entries (branch/jump flush).
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  block can accept; transfer when in_valid && in_ready at posedge.
REQ-009 in_data  input  DATA_W  upstream payload (packed pc/aluop/alusel/operands/imm/wd/wreg).
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at posedge.
REQ-012 out_data  output  DATA_W  head-entry payload, driven from a register.
REQ-013 occ  output  2  number of held entries: 0, 1 or 2.
REQ-014 bp_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 SHALL hold two entries, MAIN (drives out_data) and SKID; state is EMPTY (occ=0), ONE (occ=1) or FULL (occ=2).
REQ-016 in_ready SHALL equal (occ!=2) && rst==1, is combinational from state only, and never depends on out_ready.
REQ-017 out_valid SHALL equal (occ!=0) and be registered.
REQ-018 EMPTY: in fire -> MAIN=in_data, go to ONE; otherwise stay.
REQ-019 ONE: in fire && out fire -> MAIN=in_data, stay ONE; out fire only -> EMPTY; in fire only -> SKID=in_data, go to FULL; neither -> hold.
REQ-020 FULL: out fire -> MAIN=SKID, go to ONE; otherwise hold both entries; no input is accepted.
REQ-021 On any transition to EMPTY, out_data SHALL be loaded with NOP_VAL.
REQ-022 Latency: an entry accepted into an empty block SHALL appear on out_data/out_valid one cycle later.
REQ-023 Throughput: with out_ready held at 1, SHALL accept and emit one entry per cycle with no bubbles.
REQ-024 Ordering SHALL be strictly FIFO; no entry is duplicated or lost except by flush.
REQ-025 flush_i=1 at posedge SHALL force EMPTY, out_valid=0 and out_data=NOP_VAL, overriding every handshake; an in_data offered that cycle is discarded even though in_ready=1.
REQ-026 An out fire in the same cycle as flush_i SHALL count as consumed by downstream; the block is empty afterwards.
REQ-027 bp_cnt SHALL increment by 1 each posedge where out_valid=1 and out_ready=0, and saturate at all-ones.
REQ-028 bp_cnt SHALL NOT be cleared by flush_i.
REQ-029 in_valid while in_ready=0 SHALL have no effect; upstream holds its data.

Reset
REQ-030 rst=0 at posedge SHALL set occ=0, out_valid=0, out_data=NOP_VAL, SKID=NOP_VAL and bp_cnt=0.
REQ-031 in_ready SHALL be 0 while rst=0.
REQ-032 Reset SHALL take priority over flush_i and over all handshakes, including in mid-transfer and in the FULL state.

Verification
REQ-033 Reset then stream: hold rst=0 for 2 cycles, then drive 0x1..0x8 back-to-back with out_ready=1 -> out_data 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first accept; occ stays 1; bp_cnt=0.
REQ-034 Skid fill: out_ready=0, offer 0xA then 0xB then 0xC -> 0xA and 0xB accepted, occ=2, in_ready=0, 0xC held; raise out_ready -> outputs 0xA, 0xB, 0xC in order; bp_cnt equals the count of stalled cycles.
REQ-035 Flush while FULL, with in_valid=1 carrying 0xD -> next cycle occ=0, out_valid=0, out_data=NOP_VAL, 0xD never appears; bp_cnt unchanged.
REQ-036 Saturation: CNT_W=4, out_ready=0 for 20 cycles with one entry held -> bp_cnt reaches 15 and stays there.
REQ-037 Reset in FULL: rst=0 for 1 cycle with occ=2 -> all Reset values hold; in_ready returns to 1 the cycle after rst=1.
REQ-038 Random valid/ready with a scoreboard, DATA_W=1 and DATA_W=256 -> output sequence equals accepted sequence minus flushed entries; occ never exceeds 2.

Source files
------------

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// pipe_skid_reg: two-entry skid register with flush and back-pressure count.
// Revision: 1.0
// ============================================================================
module pipe_skid_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bp_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    bp_q, bp_d;
  logic                in_fire;
  logic                out_fire;

  assign in_ready  = rst && (state_q != S_FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occ       = state_q;
  assign bp_cnt    = bp_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          main_d  = NOP_VAL;
          state_d = S_EMPTY;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = NOP_VAL;
          state_d = S_ONE;
        end
      end
      default: begin
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
        state_d = S_EMPTY;
      end
    endcase
    // Flush overrides every handshake, including an offered input.
    if (flush_i) begin
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
      state_d = S_EMPTY;
    end
    valid_d = (state_d != S_EMPTY);
    bp_d    = bp_q;
    if (valid_q && !out_ready && !(&bp_q)) begin
      bp_d = bp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      valid_q <= 1'b0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      bp_q    <= bp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_skid_reg: a 256-bit and a 1-bit instance share control inputs and
// are compared against a queue-based model. Revision: 1.0
// ============================================================================
module tb_pipe_skid_reg;

  localparam logic [255:0] NOP_W = {8{32'hA5A5_5A5A}};
  localparam logic [0:0]   NOP_N = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         iv = 1'b0;
  logic         ordy = 1'b0;
  logic [255:0] din = '0;
  logic [0:0]   din_n;

  logic         in_ready_w, out_valid_w, in_ready_n, out_valid_n;
  logic [255:0] out_data_w;
  logic [0:0]   out_data_n;
  logic [1:0]   occ_w, occ_n;
  logic [3:0]   bp_w;
  logic [15:0]  bp_n;

  logic [255:0] mq[$];
  int unsigned  bp_m = 0;
  int           checks = 0;
  int           failures = 0;

  assign din_n = din[0:0];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(256), .NOP_VAL(NOP_W), .CNT_W(4)) u_wide (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid(iv), .in_ready(in_ready_w),
    .in_data(din), .out_valid(out_valid_w), .out_ready(ordy), .out_data(out_data_w),
    .occ(occ_w), .bp_cnt(bp_w)
  );

  pipe_skid_reg #(.DATA_W(1), .NOP_VAL(NOP_N), .CNT_W(16)) u_narrow (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid(iv), .in_ready(in_ready_n),
    .in_data(din_n), .out_valid(out_valid_n), .out_ready(ordy), .out_data(out_data_n),
    .occ(occ_n), .bp_cnt(bp_n)
  );

  task automatic cmp(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model state.
  task automatic check(input string tag);
    int          n;
    logic [255:0] hw;
    logic [0:0]   hn;
    n  = mq.size();
    hw = (n != 0) ? mq[0] : NOP_W;
    hn = (n != 0) ? mq[0][0:0] : NOP_N;
    cmp({tag, ":occ_w"},   256'(occ_w),       256'(n));
    cmp({tag, ":vld_w"},   256'(out_valid_w), 256'(n != 0));
    cmp({tag, ":dat_w"},   out_data_w,        hw);
    cmp({tag, ":rdy_w"},   256'(in_ready_w),  256'(rst && n < 2));
    cmp({tag, ":bp_w"},    256'(bp_w),        256'((bp_m > 15) ? 15 : bp_m));
    cmp({tag, ":occ_n"},   256'(occ_n),       256'(n));
    cmp({tag, ":vld_n"},   256'(out_valid_n), 256'(n != 0));
    cmp({tag, ":dat_n"},   256'(out_data_n),  256'(hn));
    cmp({tag, ":rdy_n"},   256'(in_ready_n),  256'(rst && n < 2));
    cmp({tag, ":bp_n"},    256'(bp_n),        256'((bp_m > 65535) ? 65535 : bp_m));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [255:0] d, input logic o, input string tag);
    bit can_in, can_out;
    rst = r; flush = f; iv = v; din = d; ordy = o;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      bp_m = 0;
    end else begin
      if (mq.size() != 0 && !o) bp_m++;
      can_in  = mq.size() < 2;
      can_out = (mq.size() != 0) && o;
      if (f) begin
        mq.delete();
      end else begin
        if (can_out) void'(mq.pop_front());
        if (v && can_in) mq.push_back(d);
      end
    end
    #1;
    check(tag);
  endtask

  initial begin
    // Reset, then stream 1..8 back-to-back.
    step(0, 0, 0, '0, 0, "rst0");
    step(0, 0, 1, 256'h55, 1, "rst1");
    cmp("rst_bp", 256'(bp_w), 256'(0));
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 256'(i), 1, "stream");
      cmp("stream_head", out_data_w, 256'(i));
    end
    step(1, 0, 0, '0, 1, "drain");

    // Skid fill with stalled downstream.
    step(1, 0, 1, 256'hA, 0, "skidA");
    step(1, 0, 1, 256'hB, 0, "skidB");
    step(1, 0, 1, 256'hC, 0, "skidC0");
    step(1, 0, 1, 256'hC, 0, "skidC1");
    cmp("skid_occ", 256'(occ_w), 256'(2));
    cmp("skid_rdy", 256'(in_ready_w), 256'(0));
    cmp("skid_bp", 256'(bp_w), 256'(3));
    step(1, 0, 1, 256'hC, 1, "unstall0");
    cmp("unstall_B", out_data_w, 256'hB);
    step(1, 0, 1, 256'hC, 1, "unstall1");
    cmp("unstall_C", out_data_w, 256'hC);
    step(1, 0, 0, '0, 1, "unstall2");

    // Flush while FULL with an input offered.
    step(1, 0, 1, 256'h21, 0, "ffill0");
    step(1, 0, 1, 256'h22, 0, "ffill1");
    step(1, 1, 1, 256'hD, 1, "flush");
    cmp("flush_vld", 256'(out_valid_w), 256'(0));
    cmp("flush_dat", out_data_w, NOP_W);
    cmp("flush_bp", 256'(bp_w), 256'(4));
    step(1, 0, 0, '0, 1, "postflush");

    // Saturate the 4-bit counter.
    step(1, 0, 1, 256'h31, 0, "sat_in");
    for (int i = 0; i < 20; i++) step(1, 0, 0, '0, 0, "sat");
    cmp("sat_bp", 256'(bp_w), 256'(15));

    // Reset while FULL with a transfer offered.
    step(1, 0, 1, 256'h32, 0, "rfull");
    cmp("rfull_occ", 256'(occ_w), 256'(2));
    step(0, 1, 1, 256'h33, 1, "rst_full");
    cmp("rst_full_bp", 256'(bp_w), 256'(0));
    cmp("rst_full_rdy", 256'(in_ready_w), 256'(0));
    step(1, 0, 0, '0, 1, "rst_release");
    cmp("release_rdy", 256'(in_ready_w), 256'(1));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(19) == 0),
           ($urandom_range(3) != 0),
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           ($urandom_range(2) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
